alu_arbiter: RTL and testbench

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_arbiter.sv | 140 ++++++++++++++
 tb/tb_alu_arbiter.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// Two-requester front end that serialises operations onto a single ALU with one op in flight.
// Define ALU_ARB_FIXED_PRIO_EN for fixed req0-over-req1 priority; round-robin otherwise.
module alu_arbiter #(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned CMD_W   = 4,
  parameter int unsigned LAT     = 1,
  parameter int unsigned LAT_MUL = 2
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [1:0]           req_valid,
  output logic [1:0]           req_ready,
  input  logic [1:0]           req_mode,
  input  logic [2*CMD_W-1:0]   req_cmd,
  input  logic [2*WIDTH-1:0]   req_opa,
  input  logic [2*WIDTH-1:0]   req_opb,
  input  logic [1:0]           req_cin,
  input  logic [3:0]           req_inp_valid,
  output logic                 CE,
  output logic                 MODE,
  output logic                 CIN,
  output logic [CMD_W-1:0]     CMD,
  output logic [WIDTH-1:0]     OPA,
  output logic [WIDTH-1:0]     OPB,
  output logic [1:0]           INP_VALID,
  input  logic [2*WIDTH-1:0]   RES,
  input  logic                 ERR,
  input  logic                 OFLOW,
  input  logic                 COUT,
  input  logic                 G,
  input  logic                 L,
  input  logic                 E,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic                 rsp_id,
  output logic [2*WIDTH-1:0]   rsp_res,
  output logic [5:0]           rsp_flags
);

  localparam int unsigned CNT_W = 4;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] lat_sel;
  logic [1:0]       gnt;
  logic             sel;
  logic             is_mul;
  logic             prio;   // 1: req1 wins a tie

  // Grant is a same-cycle handshake, only offered while idle and out of reset
  always_comb begin
    gnt = 2'b00;
    if (RST && state == S_IDLE) begin
      if (req_valid == 2'b11) gnt = prio ? 2'b10 : 2'b01;
      else                    gnt = req_valid;
    end
  end

  assign req_ready = gnt;
  assign sel       = gnt[1];
  assign is_mul    = MODE && (CMD == CMD_W'(9) || CMD == CMD_W'(10));
  assign lat_sel   = is_mul ? CNT_W'(LAT_MUL) : CNT_W'(LAT);

  always_ff @(posedge CLK) begin
    if (!RST) state <= S_IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:  if (|gnt) state_nxt = S_ISSUE;
      S_ISSUE: state_nxt = S_WAIT;
      S_WAIT:  if (cnt == CNT_W'(1)) state_nxt = S_RESP;
      S_RESP:  if (rsp_ready) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // ALU drive is loaded at grant so CE is already high during the issue cycle
  always_ff @(posedge CLK) begin
    if (!RST) begin
      prio      <= 1'b0;
      cnt       <= '0;
      CE        <= 1'b0;
      MODE      <= 1'b0;
      CIN       <= 1'b0;
      CMD       <= '0;
      OPA       <= '0;
      OPB       <= '0;
      INP_VALID <= 2'b00;
      rsp_valid <= 1'b0;
      rsp_id    <= 1'b0;
      rsp_res   <= '0;
      rsp_flags <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (|gnt) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
            prio      <= 1'b0;
`else
            prio      <= gnt[0];
`endif
            CE        <= 1'b1;
            MODE      <= req_mode[sel];
            CIN       <= req_cin[sel];
            CMD       <= sel ? req_cmd[2*CMD_W-1:CMD_W] : req_cmd[CMD_W-1:0];
            OPA       <= sel ? req_opa[2*WIDTH-1:WIDTH] : req_opa[WIDTH-1:0];
            OPB       <= sel ? req_opb[2*WIDTH-1:WIDTH] : req_opb[WIDTH-1:0];
            INP_VALID <= sel ? req_inp_valid[3:2] : req_inp_valid[1:0];
            rsp_id    <= sel;
          end
        end
        S_ISSUE: cnt <= lat_sel;
        S_WAIT: begin
          cnt <= cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) begin
            rsp_res   <= RES;
            rsp_flags <= {ERR, OFLOW, COUT, G, L, E};
            rsp_valid <= 1'b1;
            CE        <= 1'b0;
            INP_VALID <= 2'b00;
          end
        end
        S_RESP: if (rsp_ready) rsp_valid <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: transaction-timeline model plus a latency-aware ALU stub.
module tb_alu_arbiter;

  localparam int unsigned LAT_C  = 1;
  localparam int unsigned LMUL_C = 2;

  typedef struct packed {
    logic       mode;
    logic [3:0] cmd;
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic [1:0] inp;
  } op_t;

  logic        CLK, RST;
  logic [1:0]  req_valid, req_ready, req_mode, req_cin;
  logic [7:0]  req_cmd;
  logic [15:0] req_opa, req_opb;
  logic [3:0]  req_inp_valid;
  logic        CE, MODE, CIN;
  logic [3:0]  CMD;
  logic [7:0]  OPA, OPB;
  logic [1:0]  INP_VALID;
  logic [15:0] RES;
  logic        f_err, f_ofl, f_cout, f_g, f_l, f_e;
  logic        rsp_valid, rsp_ready, rsp_id;
  logic [15:0] rsp_res;
  logic [5:0]  rsp_flags;

  alu_arbiter #(.WIDTH(8), .CMD_W(4), .LAT(LAT_C), .LAT_MUL(LMUL_C)) dut (
    .CLK(CLK), .RST(RST),
    .req_valid(req_valid), .req_ready(req_ready), .req_mode(req_mode),
    .req_cmd(req_cmd), .req_opa(req_opa), .req_opb(req_opb), .req_cin(req_cin),
    .req_inp_valid(req_inp_valid),
    .CE(CE), .MODE(MODE), .CIN(CIN), .CMD(CMD), .OPA(OPA), .OPB(OPB), .INP_VALID(INP_VALID),
    .RES(RES), .ERR(f_err), .OFLOW(f_ofl), .COUT(f_cout), .G(f_g), .L(f_l), .E(f_e),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_res(rsp_res), .rsp_flags(rsp_flags)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  function automatic int lat_of(input logic mode, input logic [3:0] cmd);
    return (mode && (cmd == 4'd9 || cmd == 4'd10)) ? int'(LMUL_C) : int'(LAT_C);
  endfunction

  // Reference ALU: {ERR,OFLOW,COUT,G,L,E,RES}
  function automatic logic [21:0] alu_fn(input logic mode, input logic [3:0] cmd,
                                         input logic [7:0] a, input logic [7:0] b, input logic cin);
    logic [15:0] r;
    if (mode) begin
      case (cmd)
        4'd0:    r = 16'(a) + 16'(b) + 16'(cin);
        4'd9:    r = 16'(a) * 16'(b);
        4'd10:   r = (16'(a) + 16'd1) * (16'(b) + 16'd1);
        default: r = {cmd, 4'h0, a ^ b};
      endcase
    end else begin
      r = {a & b, a | b};
    end
    return {mode && (cmd > 4'd10), r[8], cin, a > b, a < b, a == b, r};
  endfunction

  // ALU stub: the true result is visible only in the cycle that is exactly the latency after issue
  int age = 0;
  logic [21:0] alu_out;
  always @(posedge CLK) age <= CE ? age + 1 : 0;
  always_comb begin
    alu_out = {6'h15, 16'hBAD0 ^ 16'(cyc)};
    if (CE && age == lat_of(MODE, CMD)) alu_out = alu_fn(MODE, CMD, OPA, OPB, CIN);
  end
  assign {f_err, f_ofl, f_cout, f_g, f_l, f_e, RES} = alu_out;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual %0h required %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // Model state
  op_t  q0[$];
  op_t  q1[$];
  int   gnt_log[$];
  logic busy = 1'b0, prio = 1'b0, after_rst = 1'b0, m_id = 1'b0, ghost1 = 1'b0;
  op_t  m_op;
  int   m_g = 0, m_lat = 0, rsp_hold = 0, wc = 0;
  logic [21:0] m_exp;
  logic [15:0] last_res = '0;
  logic        last_id = 1'b0;
  logic [1:0]  acc;

  function automatic op_t mk(input logic mode, input logic [3:0] cmd, input logic [7:0] a,
                             input logic [7:0] b, input logic cin, input logic [1:0] inp);
    op_t o;
    o.mode = mode; o.cmd = cmd; o.a = a; o.b = b; o.cin = cin; o.inp = inp;
    return o;
  endfunction

  function automatic logic [1:0] arb(input logic [1:0] v);
`ifdef ALU_ARB_FIXED_PRIO_EN
    return v[0] ? 2'b01 : (v[1] ? 2'b10 : 2'b00);
`else
    if (v == 2'b11) return prio ? 2'b10 : 2'b01;
    return v;
`endif
  endfunction

  task automatic model_cycle();
    logic [1:0] eg;
    logic ce_exp, rv_exp;
    int i;
    if (!RST) begin
      chk("ready_in_reset", 32'(req_ready), 0);
      busy = 1'b0; prio = 1'b0; after_rst = 1'b1;
      return;
    end
    if (after_rst) begin
      chk("rst_ctrl", 32'({CE, MODE, CIN, CMD, INP_VALID, rsp_valid, rsp_id, rsp_flags}), 0);
      chk("rst_data", {OPA, OPB, rsp_res}, 0);
      after_rst = 1'b0;
    end
    if (!busy) begin
      eg = arb(req_valid);
      chk("req_ready", 32'(req_ready), 32'(eg));
      chk("idle_outputs", 32'({CE, INP_VALID, rsp_valid}), 0);
      if (eg != 2'b00) begin
        i = eg[1] ? 1 : 0;
        m_id  = eg[1];
        m_op  = mk(req_mode[i], req_cmd[i*4 +: 4], req_opa[i*8 +: 8], req_opb[i*8 +: 8],
                   req_cin[i], req_inp_valid[i*2 +: 2]);
        m_g   = cyc;
        m_lat = lat_of(m_op.mode, m_op.cmd);
        m_exp = alu_fn(m_op.mode, m_op.cmd, m_op.a, m_op.b, m_op.cin);
        prio  = eg[0];
        busy  = 1'b1;
        gnt_log.push_back(i);
      end
    end else begin
      ce_exp = (cyc >= m_g + 1) && (cyc <= m_g + 1 + m_lat);
      rv_exp = (cyc >= m_g + 2 + m_lat);
      chk("ready_busy", 32'(req_ready), 0);
      chk("ce", 32'(CE), 32'(ce_exp));
      chk("inp_valid", 32'(INP_VALID), ce_exp ? 32'(m_op.inp) : 0);
      if (ce_exp)
        chk("alu_ctrl", 32'({MODE, CMD, CIN, OPA, OPB}),
            32'({m_op.mode, m_op.cmd, m_op.cin, m_op.a, m_op.b}));
      chk("rsp_valid", 32'(rsp_valid), 32'(rv_exp));
      if (rv_exp) begin
        chk("rsp_id", 32'(rsp_id), 32'(m_id));
        chk("rsp_res", 32'(rsp_res), 32'(m_exp[15:0]));
        chk("rsp_flags", 32'(rsp_flags), 32'(m_exp[21:16]));
        if (rsp_ready) begin
          busy = 1'b0; last_res = rsp_res; last_id = rsp_id;
        end
      end
    end
  endtask

  task automatic drive();
    op_t o;
    logic v;
    for (int i = 0; i < 2; i++) begin
      v = 1'b0; o = '0;
      if (i == 0 && q0.size() > 0) begin v = 1'b1; o = q0[0]; end
      if (i == 1) begin
        if (q1.size() > 0) begin v = 1'b1; o = q1[0]; end
        else if (ghost1)   begin v = 1'b1; o = mk(1'b1, 4'd3, 8'hAA, 8'h55, 1'b0, 2'b11); end
      end
      req_valid[i]           = v;
      req_mode[i]            = o.mode;
      req_cmd[i*4 +: 4]      = o.cmd;
      req_opa[i*8 +: 8]      = o.a;
      req_opb[i*8 +: 8]      = o.b;
      req_cin[i]             = o.cin;
      req_inp_valid[i*2 +: 2] = o.inp;
    end
    rsp_ready = (wc >= rsp_hold);
  endtask

  task automatic step();
    @(negedge CLK);
    model_cycle();
    acc = req_valid & req_ready;
    if (rsp_valid) wc = rsp_ready ? 0 : wc + 1;
    @(posedge CLK);
    #1;
    if (acc[0] && q0.size() > 0) q0.delete(0);
    if (acc[1] && q1.size() > 0) q1.delete(0);
    drive();
  endtask

  task automatic run_idle(input string name, input int budget);
    int n;
    n = 0;
    step();
    while ((q0.size() > 0 || q1.size() > 0 || busy) && n < budget) begin
      step();
      n++;
    end
    chk({name, "_done"}, 32'(n < budget), 1);
  endtask

  initial begin
    int exp_order [4];
    int base, n;
    logic [21:0] pin;
    RST = 1'b0;
    req_valid = '0; req_mode = '0; req_cmd = '0; req_opa = '0; req_opb = '0;
    req_cin = '0; req_inp_valid = '0; rsp_ready = 1'b1;
    drive();
    repeat (3) step();
    RST = 1'b1;
    step();

    // Pin the reference ALU against hand-computed values
    pin = alu_fn(1'b1, 4'd0, 8'h0F, 8'h01, 1'b0);
    chk("pin_add", 32'(pin), 32'({6'b000100, 16'h0010}));
    pin = alu_fn(1'b1, 4'd9, 8'd3, 8'd4, 1'b0);
    chk("pin_mul", 32'(pin), 32'({6'b000010, 16'h000C}));
    pin = alu_fn(1'b1, 4'd10, 8'd2, 8'd5, 1'b0);
    chk("pin_mul2", 32'(pin), 32'({6'b000010, 16'h0012}));

    // Both requesters continuously valid: grant order
    gnt_log.delete();
    for (int i = 0; i < 4; i++) begin
      q0.push_back(mk(1'(i), 4'(i + 8), 8'(8'h10 + i), 8'(8'h03 * i), 1'(i), 2'b11));
      q1.push_back(mk(1'(~i), 4'(i + 9), 8'(8'hA0 - i), 8'(8'h21 + i), 1'b0, 2'(i)));
    end
    drive();
    run_idle("both", 200);
`ifdef ALU_ARB_FIXED_PRIO_EN
    exp_order = '{0, 0, 0, 0};
`else
    exp_order = '{0, 1, 0, 1};
`endif
    chk("order_count", 32'(gnt_log.size()), 8);
    for (int i = 0; i < 4; i++)
      if (i < gnt_log.size()) chk($sformatf("order%0d", i), 32'(gnt_log[i]), 32'(exp_order[i]));

    // Single req0 ADD
    q0.push_back(mk(1'b1, 4'd0, 8'h0F, 8'h01, 1'b0, 2'b11));
    drive();
    run_idle("add", 40);
    chk("add_res", 32'(last_res), 32'h0010);
    chk("add_id", 32'(last_id), 0);

    // Multiply latency on req1
    q1.push_back(mk(1'b1, 4'd9, 8'd3, 8'd4, 1'b0, 2'b11));
    drive();
    run_idle("mul", 40);
    chk("mul_res", 32'(last_res), 32'h000C);
    chk("mul_id", 32'(last_id), 1);

    // Response back-pressure with req1 pending
    rsp_hold = 10; wc = 0;
    q0.push_back(mk(1'b0, 4'd10, 8'hC3, 8'h3C, 1'b1, 2'b01));
    drive();
    step();
    q1.push_back(mk(1'b1, 4'd10, 8'd2, 8'd5, 1'b0, 2'b10));
    drive();
    run_idle("hold", 60);
    chk("hold_last_id", 32'(last_id), 1);
    chk("hold_last_res", 32'(last_res), 32'h0012);
    rsp_hold = 0; wc = 0;

    // req1 raised and withdrawn while busy must not be granted
    base = gnt_log.size();
    rsp_hold = 3; wc = 0;
    q0.push_back(mk(1'b1, 4'd1, 8'h44, 8'h44, 1'b0, 2'b11));
    drive();
    step();
    ghost1 = 1'b1; drive();
    step(); step();
    ghost1 = 1'b0; drive();
    run_idle("ghost", 40);
    chk("ghost_grants", 32'(gnt_log.size()), 32'(base + 1));
    rsp_hold = 0; wc = 0;

    // Reset during WAIT aborts the op; req1 served afterwards
    q0.push_back(mk(1'b1, 4'd9, 8'd7, 8'd9, 1'b0, 2'b11));
    drive();
    n = 0;
    step();
    while (!(busy && cyc == m_g + 2) && n < 50) begin step(); n++; end
    chk("reach_wait", 32'(n < 50), 1);
    RST = 1'b0;
    step();
    RST = 1'b1;
    step();
    q1.push_back(mk(1'b1, 4'd10, 8'd2, 8'd5, 1'b0, 2'b11));
    drive();
    run_idle("post_rst", 40);
    chk("post_rst_id", 32'(last_id), 1);
    chk("post_rst_res", 32'(last_res), 32'h0012);

    repeat (2) step();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
